ysyx_041461_if_ctrl: RTL and testbench

YSYX_041461_IF_CTRL -- requirements
Module: ysyx_041461_IF_ctrl

---
 rtl/ysyx_041461_if_ctrl_pkg.sv | 22 ++
 rtl/ysyx_041461_if_ctrl_redirect_arb.sv | 38 +++
 rtl/ysyx_041461_if_ctrl.sv | 123 ++++++++++++
 tb/tb_ysyx_041461_if_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_if_ctrl_pkg.sv
// Shared encodings for the instruction-fetch controller: PC-register control
// codes and FSM state values.
package ysyx_041461_if_ctrl_pkg;

  // Write-back control into the PC register
  localparam logic [1:0] WB_NOP   = 2'b00;
  localparam logic [1:0] WB_MTVEC = 2'b01;
  localparam logic [1:0] WB_MEPC  = 2'b10;

  // Decode-stage control into the PC register
  localparam logic ID_NOP = 1'b0;
  localparam logic ID_PC  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_e;

endpackage

// File: rtl/ysyx_041461_if_ctrl_redirect_arb.sv
// Redirect arbiter: wb_trap > wb_mret > id_redirect. Produces the PC-register
// control codes, the redirect strobe and the decode-stage flush.
module ysyx_041461_IF_redirect_arb
  import ysyx_041461_if_ctrl_pkg::*;
(
  input  logic       en,
  input  logic       wb_trap,
  input  logic       wb_mret,
  input  logic       id_redirect,
  output logic       redirect,
  output logic       flush_id,
  output logic [1:0] ctrl_from_wb,
  output logic       ctrl_from_id
);

  // Fixed-priority select; nothing is honoured while the fetcher is idle
  always_comb begin
    redirect     = 1'b0;
    flush_id     = 1'b0;
    ctrl_from_wb = WB_NOP;
    ctrl_from_id = ID_NOP;
    if (en) begin
      if (wb_trap) begin
        redirect     = 1'b1;
        flush_id     = 1'b1;
        ctrl_from_wb = WB_MTVEC;
      end else if (wb_mret) begin
        redirect     = 1'b1;
        flush_id     = 1'b1;
        ctrl_from_wb = WB_MEPC;
      end else if (id_redirect) begin
        redirect     = 1'b1;
        ctrl_from_id = ID_PC;
      end
    end
  end

endmodule

// File: rtl/ysyx_041461_if_ctrl.sv
// Instruction-fetch controller: issues one imem request per instruction, holds
// the fetched word for decode, and steers the PC register on redirects.
// Optional performance counters are built when YSYX_041461_IF_PERF_EN is defined.
module ysyx_041461_if_ctrl
  import ysyx_041461_if_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_trap,
  input  logic        wb_mret,
  input  logic        id_redirect,
  input  logic        id_ready,
  input  logic [63:0] pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        ifreg_enable,
  output logic        ifreg_ctrl_fromID,
  output logic [1:0]  ifreg_ctrl_fromWB,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        flush_id,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_redirect_cnt
);

  state_e      state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        redirect;

  ysyx_041461_IF_redirect_arb u_arb (
    .en           (state_q != S_IDLE),
    .wb_trap      (wb_trap),
    .wb_mret      (wb_mret),
    .id_redirect  (id_redirect),
    .redirect     (redirect),
    .flush_id     (flush_id),
    .ctrl_from_wb (ifreg_ctrl_fromWB),
    .ctrl_from_id (ifreg_ctrl_fromID)
  );

  // Next-state logic. A request that is not accepted while a redirect fires is
  // simply not counted as outstanding; REQ re-presents it at the new pc.
  // A redirect in DROP adds no new outstanding beat, so the pending beat still
  // releases DROP when it arrives.
  always_comb begin
    state_d    = state_q;
    if_valid_d = 1'b0;
    if_inst_d  = if_inst_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect)            state_d = imem_req_ready ? S_DROP : S_REQ;
        else if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) state_d = imem_resp_valid ? S_REQ : S_DROP;
        else if (imem_resp_valid) begin
          if_inst_d  = imem_resp_data;
          if_valid_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || id_ready) state_d = S_REQ;
        else                      if_valid_d = 1'b1;
      end
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and fetched-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign ifreg_enable   = redirect | ((state_q == S_HOLD) & id_ready);
  assign if_valid       = if_valid_q;
  assign if_inst        = if_inst_q;

`ifdef YSYX_041461_IF_PERF_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] redir_cnt_q, redir_cnt_d;

  // Counters advance on decode handshakes and accepted redirects; wrap freely
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {63'h0, (state_q == S_HOLD) & id_ready};
    redir_cnt_d = redir_cnt_q + {63'h0, redirect};
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 64'h0;
      redir_cnt_q <= 64'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`else
  assign perf_fetch_cnt    = 64'h0;
  assign perf_redirect_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_ysyx_041461_if_ctrl.sv
// Directed bench for the fetch controller with a small PC-register model.
module tb_ysyx_041461_if_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [63:0] MTVEC  = 64'h8000_1000;
  localparam logic [63:0] MEPC   = 64'h8000_2000;
  localparam logic [63:0] IDPC   = 64'h8000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_trap = 1'b0, wb_mret = 1'b0, id_redirect = 1'b0, id_ready = 1'b0;
  logic [63:0] pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        ifreg_enable, ifreg_ctrl_fromID;
  logic [1:0]  ifreg_ctrl_fromWB;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        flush_id;
  logic [63:0] perf_fetch_cnt, perf_redirect_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_041461_if_ctrl dut (
    .clk(clk), .rst(rst), .wb_trap(wb_trap), .wb_mret(wb_mret),
    .id_redirect(id_redirect), .id_ready(id_ready), .pc(pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .ifreg_enable(ifreg_enable),
    .ifreg_ctrl_fromID(ifreg_ctrl_fromID), .ifreg_ctrl_fromWB(ifreg_ctrl_fromWB),
    .if_valid(if_valid), .if_inst(if_inst), .flush_id(flush_id),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  // PC register model steered by the controller
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= RST_PC;
    else if (ifreg_enable) begin
      if (ifreg_ctrl_fromWB == 2'b01)      pc <= MTVEC;
      else if (ifreg_ctrl_fromWB == 2'b10) pc <= MEPC;
      else if (ifreg_ctrl_fromID)          pc <= IDPC;
      else                                 pc <= pc + 64'd4;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the first cycle after reset release (IDLE)
  task automatic do_reset();
    rst = 1'b1; wb_trap = 0; wb_mret = 0; id_redirect = 0; id_ready = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // From REQ: accept, return one beat, land in HOLD
  task automatic fetch_to_hold(input logic [31:0] data);
    imem_req_ready = 1; step();
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = data; step();
    imem_resp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0h exp=0", imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%0h exp=0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL rst_if_inst got=%0h exp=0", if_inst); end
    checks++; if (ifreg_enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%0h exp=0", ifreg_enable); end
    checks++; if ({ifreg_ctrl_fromWB, ifreg_ctrl_fromID, flush_id} !== 4'b0) begin failures++; $display("FAIL rst_ctrls got=%0h exp=0", {ifreg_ctrl_fromWB, ifreg_ctrl_fromID, flush_id}); end
    checks++; if ({perf_fetch_cnt, perf_redirect_cnt} !== 128'h0) begin failures++; $display("FAIL rst_counters got=%0h/%0h exp=0/0", perf_fetch_cnt, perf_redirect_cnt); end
  endtask

  task automatic test_basic_fetch();
    do_reset(); #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL idle_req_valid got=%0h exp=0", imem_req_valid); end
    imem_req_ready = 1; step();
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL c2_req_valid got=%0h exp=1", imem_req_valid); end
    checks++; if (imem_req_addr !== RST_PC) begin failures++; $display("FAIL c2_req_addr got=%0h exp=%0h", imem_req_addr, RST_PC); end
    step(); imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = 32'h0010_0013; #1;
    checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL c3_wait got=%0h/%0h exp=0/0", imem_req_valid, if_valid); end
    step(); imem_resp_valid = 0; #1;
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL c4_if_valid got=%0h exp=1", if_valid); end
    checks++; if (if_inst !== 32'h0010_0013) begin failures++; $display("FAIL c4_if_inst got=%0h exp=00100013", if_inst); end
    checks++; if (ifreg_enable !== 1'b0) begin failures++; $display("FAIL c4_enable_idle got=%0h exp=0", ifreg_enable); end
    id_ready = 1; #1;
    checks++; if ({ifreg_enable, ifreg_ctrl_fromWB, ifreg_ctrl_fromID} !== 4'b1000) begin failures++; $display("FAIL c4_seq_pulse got=%0h exp=8", {ifreg_enable, ifreg_ctrl_fromWB, ifreg_ctrl_fromID}); end
    step(); id_ready = 0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL c5_if_valid got=%0h exp=0", if_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 64'd4) begin failures++; $display("FAIL c5_next_req got=%0h@%0h exp=1@%0h", imem_req_valid, imem_req_addr, RST_PC + 64'd4); end
  endtask

  task automatic test_hold_stall();
    fetch_to_hold(32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (if_valid !== 1'b1 || if_inst !== 32'h1234_5678 || ifreg_enable !== 1'b0) begin failures++; $display("FAIL hold_stall%0d got=%0h/%0h/%0h exp=1/12345678/0", i, if_valid, if_inst, ifreg_enable); end
      step();
    end
  endtask

  task automatic test_trap_and_id();
    wb_trap = 1; id_redirect = 1; #1;
    checks++; if (ifreg_ctrl_fromWB !== 2'b01 || ifreg_ctrl_fromID !== 1'b0) begin failures++; $display("FAIL trap_ctrls got=%0h/%0h exp=1/0", ifreg_ctrl_fromWB, ifreg_ctrl_fromID); end
    checks++; if (flush_id !== 1'b1 || ifreg_enable !== 1'b1) begin failures++; $display("FAIL trap_flush_en got=%0h/%0h exp=1/1", flush_id, ifreg_enable); end
    step(); wb_trap = 0; id_redirect = 0; #1;
    checks++; if (if_valid !== 1'b0 || flush_id !== 1'b0) begin failures++; $display("FAIL trap_after got=%0h/%0h exp=0/0", if_valid, flush_id); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== MTVEC) begin failures++; $display("FAIL trap_req got=%0h@%0h exp=1@%0h", imem_req_valid, imem_req_addr, MTVEC); end
  endtask

  task automatic test_wait_redirect();
    imem_req_ready = 1; step();
    imem_req_ready = 0; id_redirect = 1; #1;
    checks++; if ({ifreg_enable, ifreg_ctrl_fromWB, ifreg_ctrl_fromID, flush_id} !== 5'b10010) begin failures++; $display("FAIL wait_redir got=%0h exp=12", {ifreg_enable, ifreg_ctrl_fromWB, ifreg_ctrl_fromID, flush_id}); end
    step(); id_redirect = 0; #1;
    checks++; if (imem_req_valid !== 1'b0 || ifreg_enable !== 1'b0) begin failures++; $display("FAIL drop_quiet got=%0h/%0h exp=0/0", imem_req_valid, ifreg_enable); end
    step(); imem_resp_valid = 1; imem_resp_data = 32'hDEAD_BEEF; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL drop_beat_valid got=%0h exp=0", if_valid); end
    step(); imem_resp_valid = 0; #1;
    checks++; if (if_valid !== 1'b0 || if_inst === 32'hDEAD_BEEF) begin failures++; $display("FAIL drop_discard got=%0h/%0h exp=0/not-deadbeef", if_valid, if_inst); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== IDPC) begin failures++; $display("FAIL drop_reissue got=%0h@%0h exp=1@%0h", imem_req_valid, imem_req_addr, IDPC); end
  endtask

  task automatic test_mret_req();
    imem_req_ready = 0; wb_mret = 1; #1;
    checks++; if ({ifreg_enable, ifreg_ctrl_fromWB, ifreg_ctrl_fromID, flush_id} !== 5'b11001) begin failures++; $display("FAIL mret_ctrls got=%0h exp=19", {ifreg_enable, ifreg_ctrl_fromWB, ifreg_ctrl_fromID, flush_id}); end
    step(); wb_mret = 0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== MEPC) begin failures++; $display("FAIL mret_reissue got=%0h@%0h exp=1@%0h", imem_req_valid, imem_req_addr, MEPC); end
    fetch_to_hold(32'hCAFE_F00D); #1;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'hCAFE_F00D) begin failures++; $display("FAIL mret_no_drop got=%0h/%0h exp=1/cafef00d", if_valid, if_inst); end
  endtask

  task automatic test_hold_redirect_ready();
    id_ready = 1; id_redirect = 1; #1;
    checks++; if (ifreg_enable !== 1'b1 || ifreg_ctrl_fromID !== 1'b1) begin failures++; $display("FAIL hold_redir got=%0h/%0h exp=1/1", ifreg_enable, ifreg_ctrl_fromID); end
    step(); id_ready = 0; id_redirect = 0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== IDPC) begin failures++; $display("FAIL hold_redir_pc got=%0h@%0h exp=1@%0h", imem_req_valid, imem_req_addr, IDPC); end
  endtask

  task automatic test_wait_resp_redirect();
    imem_req_ready = 1; step();
    imem_req_ready = 0; id_redirect = 1; imem_resp_valid = 1; imem_resp_data = 32'h1111_1111; step();
    id_redirect = 0; imem_resp_valid = 0; #1;
    checks++; if (imem_req_valid !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL wait_resp_redir got=%0h/%0h exp=1/0", imem_req_valid, if_valid); end
  endtask

  task automatic test_perf();
    logic [63:0] exp_f, exp_r;
`ifdef YSYX_041461_IF_PERF_EN
    exp_f = 64'd10; exp_r = 64'd3;
`else
    exp_f = 64'd0; exp_r = 64'd0;
`endif
    do_reset(); #1;
    checks++; if (perf_fetch_cnt !== 64'd0 || perf_redirect_cnt !== 64'd0) begin failures++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_redirect_cnt); end
    step();
    for (int i = 0; i < 10; i++) begin
      fetch_to_hold(32'h100 + i);
      id_ready = 1; id_redirect = (i < 3); step();
      id_ready = 0; id_redirect = 0;
    end
    #1;
    checks++; if (perf_fetch_cnt !== exp_f) begin failures++; $display("FAIL perf_fetch got=%0d exp=%0d", perf_fetch_cnt, exp_f); end
    checks++; if (perf_redirect_cnt !== exp_r) begin failures++; $display("FAIL perf_redirect got=%0d exp=%0d", perf_redirect_cnt, exp_r); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_trap_and_id();
    test_wait_redirect();
    test_mret_req();
    test_hold_redirect_ready();
    test_wait_resp_redirect();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
